// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives the pipeline register load/clear strobes and the PC write enable.
// Covers load-use stalls, taken branch/jump redirects from MEM, and multi-cycle mul/div occupancy of EX.
module pipe_hazard_ctrl #(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_RegDstData,
   input  logic             EX_MulDiv,
   input  logic             MEM_Branch,
   input  logic             MEM_Zero,
   input  logic             MEM_Jump,
   output logic             PCWrite,
   output logic             PCRedirect,
   output logic             IFID_Ld,
   output logic             IFID_Clr,
   output logic             IDEX_Ld,
   output logic             IDEX_Clr,
   output logic             EXMEM_Ld,
   output logic             EXMEM_Clr,
   output logic             MEMWB_Ld,
   output logic             Stall,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int              MD_W      = $clog2(MULDIV_CYCLES) + 1;
   localparam logic [MD_W-1:0] MD_LOAD   = MD_W'(MULDIV_CYCLES - 1);
   localparam logic [MD_W-1:0] MD_ONE    = MD_W'(1);
   localparam logic [MD_W-1:0] MD_ZERO   = '0;
   localparam bit              MD_STALLS = (MULDIV_CYCLES > 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic {
      RUN,
      MDWAIT
   } state_e;

   state_e            state_q, state_d;
   logic [MD_W-1:0]   mdCnt_q, mdCnt_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

   logic redirect;
   logic loadUse;
   logic mdStart;
   logic mdHold;

   // Hazard qualification; $0 is hard-wired so it never creates a dependency
   always_comb begin
      redirect = (MEM_Branch & MEM_Zero) | MEM_Jump;
      loadUse  = EX_MemRead && (EX_RegDstData != 5'd0) &&
                 ((EX_RegDstData == ID_Rs) || (ID_UsesRt && (EX_RegDstData == ID_Rt)));
      mdStart  = MD_STALLS && (state_q == RUN) && EX_MulDiv;
      mdHold   = (state_q == MDWAIT) && (mdCnt_q > MD_ONE);
   end

   // A redirect squashes the younger mul/div, so it also cancels any pending wait
   always_comb begin
      state_d = state_q;
      mdCnt_d = mdCnt_q;
      if (Clr || redirect) begin
         state_d = RUN;
         mdCnt_d = MD_ZERO;
      end else if (state_q == RUN) begin
         if (mdStart) begin
            state_d = MDWAIT;
            mdCnt_d = MD_LOAD;
         end
      end else begin
         if (mdCnt_q > MD_ONE) begin
            mdCnt_d = mdCnt_q - MD_ONE;
         end else begin
            state_d = RUN;
            mdCnt_d = MD_ZERO;
         end
      end
   end

   always_comb begin
      PCWrite    = 1'b1;
      PCRedirect = 1'b0;
      IFID_Ld    = 1'b1;
      IFID_Clr   = 1'b0;
      IDEX_Ld    = 1'b1;
      IDEX_Clr   = 1'b0;
      EXMEM_Ld   = 1'b1;
      EXMEM_Clr  = 1'b0;
      MEMWB_Ld   = 1'b1;
      Stall      = 1'b0;
      if (Clr) begin
         PCWrite   = 1'b0;
         IFID_Ld   = 1'b0;
         IFID_Clr  = 1'b1;
         IDEX_Ld   = 1'b0;
         IDEX_Clr  = 1'b1;
         EXMEM_Ld  = 1'b0;
         EXMEM_Clr = 1'b1;
         MEMWB_Ld  = 1'b0;
      end else if (redirect) begin
         PCRedirect = 1'b1;
         IFID_Clr   = 1'b1;
         IDEX_Clr   = 1'b1;
         EXMEM_Clr  = 1'b1;
      end else if (mdStart || mdHold) begin
         // Front end frozen while the mul/div sits in EX; MEM receives bubbles
         PCWrite   = 1'b0;
         IFID_Ld   = 1'b0;
         IDEX_Ld   = 1'b0;
         EXMEM_Clr = 1'b1;
         Stall     = 1'b1;
      end else if ((state_q == RUN) && loadUse) begin
         PCWrite  = 1'b0;
         IFID_Ld  = 1'b0;
         IDEX_Clr = 1'b1;
         Stall    = 1'b1;
      end
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (Clr) begin
         stallCnt_d = '0;
      end else if (Stall && (stallCnt_q != CNT_MAX)) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_q    <= RUN;
         mdCnt_q    <= MD_ZERO;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mdCnt_q    <= mdCnt_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign StallCycles = stallCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expected outputs, a negedge monitor compares them.
module tb_pipe_hazard_ctrl;

   localparam int MULDIV_CYCLES = 4;
   localparam int CNT_W         = 4;

   // Control vector order: PCWrite PCRedirect IFID_Ld IFID_Clr IDEX_Ld IDEX_Clr EXMEM_Ld EXMEM_Clr MEMWB_Ld Stall
   localparam logic [9:0] RST = 10'b00_01_01_01_0_0;
   localparam logic [9:0] DEF = 10'b10_10_10_10_1_0;
   localparam logic [9:0] LU  = 10'b00_00_11_10_1_1;
   localparam logic [9:0] MD  = 10'b00_00_00_11_1_1;
   localparam logic [9:0] RD  = 10'b11_11_11_11_1_0;

   logic Clk;
   logic Clr;
   logic [4:0] ID_Rs;
   logic [4:0] ID_Rt;
   logic ID_UsesRt;
   logic EX_MemRead;
   logic [4:0] EX_RegDstData;
   logic EX_MulDiv;
   logic MEM_Branch;
   logic MEM_Zero;
   logic MEM_Jump;
   logic PCWrite;
   logic PCRedirect;
   logic IFID_Ld;
   logic IFID_Clr;
   logic IDEX_Ld;
   logic IDEX_Clr;
   logic EXMEM_Ld;
   logic EXMEM_Clr;
   logic MEMWB_Ld;
   logic Stall;
   logic [CNT_W-1:0] StallCycles;

   typedef struct {
      logic [9:0]       ctl;
      logic [CNT_W-1:0] cnt;
      bit               chkCnt;
      string            name;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   pipe_hazard_ctrl #(
      .MULDIV_CYCLES(MULDIV_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .Clk          (Clk),
      .Clr          (Clr),
      .ID_Rs        (ID_Rs),
      .ID_Rt        (ID_Rt),
      .ID_UsesRt    (ID_UsesRt),
      .EX_MemRead   (EX_MemRead),
      .EX_RegDstData(EX_RegDstData),
      .EX_MulDiv    (EX_MulDiv),
      .MEM_Branch   (MEM_Branch),
      .MEM_Zero     (MEM_Zero),
      .MEM_Jump     (MEM_Jump),
      .PCWrite      (PCWrite),
      .PCRedirect   (PCRedirect),
      .IFID_Ld      (IFID_Ld),
      .IFID_Clr     (IFID_Clr),
      .IDEX_Ld      (IDEX_Ld),
      .IDEX_Clr     (IDEX_Clr),
      .EXMEM_Ld     (EXMEM_Ld),
      .EXMEM_Clr    (EXMEM_Clr),
      .MEMWB_Ld     (MEMWB_Ld),
      .Stall        (Stall),
      .StallCycles  (StallCycles)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input exp_t e);
      logic [9:0] act;
      act = {PCWrite, PCRedirect, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr,
             EXMEM_Ld, EXMEM_Clr, MEMWB_Ld, Stall};
      checks++;
      if (act !== e.ctl) begin
         failures++;
         $display("[TB] FAIL %s ctl: got=%b expected=%b", e.name, act, e.ctl);
      end
      if (e.chkCnt) begin
         checks++;
         if (StallCycles !== e.cnt) begin
            failures++;
            $display("[TB] FAIL %s StallCycles: got=%0d expected=%0d", e.name, StallCycles, e.cnt);
         end
      end
   endtask

   // Monitor: outputs are combinational, so every cycle with a queued expectation is compared mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic applyStimulus(input logic clr, input logic [4:0] rs, input logic [4:0] rt,
                                input logic usesRt, input logic memRead, input logic [4:0] dst,
                                input logic mulDiv, input logic branch, input logic zero,
                                input logic jump, input logic [9:0] expCtl,
                                input logic [CNT_W-1:0] expCnt, input bit chkCnt, input string name);
      exp_t e;
      @(posedge Clk);
      #1;
      Clr           = clr;
      ID_Rs         = rs;
      ID_Rt         = rt;
      ID_UsesRt     = usesRt;
      EX_MemRead    = memRead;
      EX_RegDstData = dst;
      EX_MulDiv     = mulDiv;
      MEM_Branch    = branch;
      MEM_Zero      = zero;
      MEM_Jump      = jump;
      e.ctl    = expCtl;
      e.cnt    = expCnt;
      e.chkCnt = chkCnt;
      e.name   = name;
      expQ.push_back(e);
   endtask

   initial begin
      Clr = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0;
      EX_RegDstData = '0; EX_MulDiv = 1'b0; MEM_Branch = 1'b0; MEM_Zero = 1'b0; MEM_Jump = 1'b0;

      // Reset for two cycles; the counter is unknown until the first reset edge
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, "reset1");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 1, "reset2");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1, "postReset");

      // Load-use on rs, then on rt, then rt not used, then $0
      applyStimulus(0, 8, 2, 0, 1, 8, 0, 0, 0, 0, LU,  0, 1, "luRs");
      applyStimulus(0, 8, 2, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 1, "luRsBubble");
      applyStimulus(0, 3, 8, 1, 1, 8, 0, 0, 0, 0, LU,  1, 1, "luRt");
      applyStimulus(0, 3, 8, 0, 1, 8, 0, 0, 0, 0, DEF, 2, 1, "rtUnused");
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, DEF, 2, 1, "regZero");

      // Mul/div occupies EX for four cycles: three stalls then release
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 2, 1, "reset3");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MD,  0, 1, "mdStart");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MD,  1, 1, "mdWait2");
      applyStimulus(0, 4, 0, 0, 1, 4, 1, 0, 0, 0, MD,  2, 1, "mdWait3");
      applyStimulus(0, 4, 0, 0, 1, 4, 1, 0, 0, 0, DEF, 3, 1, "mdDone");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 3, 1, "mdAfter");

      // Jump in MEM aborts a pending mul/div wait
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MD,  3, 1, "mdStartB");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, RD,  4, 1, "jumpInMd");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 4, 1, "runAfterJump");

      // Taken branch beats a simultaneous load-use; untaken branch does not
      applyStimulus(0, 5, 0, 0, 1, 5, 0, 1, 1, 0, RD,  4, 1, "branchOverLu");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 4, 1, "afterBranch");
      applyStimulus(0, 5, 0, 0, 1, 5, 0, 1, 0, 0, LU,  4, 1, "untakenLu");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 5, 1, "afterUntaken");

      // Reset in the middle of a mul/div wait leaves no residual stall
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MD,  5, 1, "mdStartC");
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, RST, 6, 1, "clrInMd");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1, "afterClr1");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1, "afterClr2");

      // Twenty load-use stalls into a 4-bit counter must stop at 15
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 9, 0, 0, 1, 9, 0, 0, 0, 0, LU,  CNT_W'((i > 15) ? 15 : i), 1, "satLu");
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, CNT_W'((i + 1 > 15) ? 15 : i + 1), 1, "satBubble");
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 15, 1, "satHold");

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge Clk);
      #1;
      if (expQ.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain: got=%0d pending expected=0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
